// File: rtl/idli_sqi_arb_m.sv
// idli_sqi_arb_m: shares the single SQI controller between instruction fetch (FE)
// and load/store (LS). Only one transaction is in flight at a time. It is held
// toward SQI until the controller acks, and its read data and a one-cycle ack
// are then returned to the winner.
// Optional feature macro: IDLI_ARB_STARVE_EN bounds how many consecutive LS
// grants may be made while FE is waiting.
module idli_sqi_arb_m #(
   parameter int unsigned ADDR_W     = 16,
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic              i_arb_gck,
   input  logic              i_arb_rst_n,
   input  logic              i_arb_fe_req,
   input  logic [ADDR_W-1:0] i_arb_fe_addr,
   output logic              o_arb_fe_ack,
   output logic [DATA_W-1:0] o_arb_fe_rdata,
   input  logic              i_arb_ls_req,
   input  logic              i_arb_ls_wr,
   input  logic [ADDR_W-1:0] i_arb_ls_addr,
   input  logic [DATA_W-1:0] i_arb_ls_wdata,
   output logic              o_arb_ls_ack,
   output logic [DATA_W-1:0] o_arb_ls_rdata,
   output logic              o_arb_sqi_req,
   output logic              o_arb_sqi_wr,
   output logic [ADDR_W-1:0] o_arb_sqi_addr,
   output logic [DATA_W-1:0] o_arb_sqi_wdata,
   input  logic              i_arb_sqi_ack,
   input  logic [DATA_W-1:0] i_arb_sqi_rdata
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_FE = 2'd1,
      BUSY_LS = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              sqi_wr_q, sqi_wr_d;
   logic [ADDR_W-1:0] sqi_addr_q, sqi_addr_d;
   logic [DATA_W-1:0] sqi_wdata_q, sqi_wdata_d;
   logic              fe_ack_q, fe_ack_d;
   logic              ls_ack_q, ls_ack_d;
   logic [DATA_W-1:0] fe_rdata_q, fe_rdata_d;
   logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;

   logic fe_eff;
   logic ls_eff;
   logic fe_win;

   // A requester is masked during its own ack cycle so a held req cannot re-grant.
   assign fe_eff = i_arb_fe_req & ~fe_ack_q;
   assign ls_eff = i_arb_ls_req & ~ls_ack_q;

`ifdef IDLI_ARB_STARVE_EN
   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0] starve_q, starve_d;

   // FE wins when alone, or when LS has used up its run of grants while FE waited.
   assign fe_win = fe_eff & (~ls_eff | (starve_q == CNT_MAX));

   // Starvation counter next value: count LS grants over a waiting FE, clear on FE grant.
   always_comb begin
      starve_d = starve_q;
      if (state_q == IDLE) begin
         if (fe_win) begin
            starve_d = '0;
         end else if (ls_eff && fe_eff && (starve_q != CNT_MAX)) begin
            starve_d = starve_q + CNT_W'(1);
         end
      end
   end

   // Starvation counter register.
   always_ff @(posedge i_arb_gck) begin
      if (!i_arb_rst_n) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end
`else
   logic unused_starve_max;

   assign unused_starve_max = ^(4'(STARVE_MAX));
   assign fe_win            = fe_eff & ~ls_eff;
`endif

   // Next-state and registered-output values: grant in IDLE, complete on SQI ack.
   always_comb begin
      state_d     = state_q;
      sqi_wr_d    = sqi_wr_q;
      sqi_addr_d  = sqi_addr_q;
      sqi_wdata_d = sqi_wdata_q;
      fe_ack_d    = 1'b0;
      ls_ack_d    = 1'b0;
      fe_rdata_d  = fe_rdata_q;
      ls_rdata_d  = ls_rdata_q;
      case (state_q)
         IDLE: begin
            if (fe_win) begin
               state_d     = BUSY_FE;
               sqi_wr_d    = 1'b0;
               sqi_addr_d  = i_arb_fe_addr;
               sqi_wdata_d = '0;
            end else if (ls_eff) begin
               state_d     = BUSY_LS;
               sqi_wr_d    = i_arb_ls_wr;
               sqi_addr_d  = i_arb_ls_addr;
               sqi_wdata_d = i_arb_ls_wdata;
            end
         end
         BUSY_FE: begin
            if (i_arb_sqi_ack) begin
               state_d    = IDLE;
               fe_ack_d   = 1'b1;
               fe_rdata_d = i_arb_sqi_rdata;
            end
         end
         BUSY_LS: begin
            if (i_arb_sqi_ack) begin
               state_d    = IDLE;
               ls_ack_d   = 1'b1;
               ls_rdata_d = sqi_wr_q ? '0 : i_arb_sqi_rdata;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge i_arb_gck) begin
      if (!i_arb_rst_n) begin
         state_q     <= IDLE;
         sqi_wr_q    <= 1'b0;
         sqi_addr_q  <= '0;
         sqi_wdata_q <= '0;
         fe_ack_q    <= 1'b0;
         ls_ack_q    <= 1'b0;
         fe_rdata_q  <= '0;
         ls_rdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         sqi_wr_q    <= sqi_wr_d;
         sqi_addr_q  <= sqi_addr_d;
         sqi_wdata_q <= sqi_wdata_d;
         fe_ack_q    <= fe_ack_d;
         ls_ack_q    <= ls_ack_d;
         fe_rdata_q  <= fe_rdata_d;
         ls_rdata_q  <= ls_rdata_d;
      end
   end

   assign o_arb_sqi_req   = (state_q != IDLE);
   assign o_arb_sqi_wr    = sqi_wr_q;
   assign o_arb_sqi_addr  = sqi_addr_q;
   assign o_arb_sqi_wdata = sqi_wdata_q;
   assign o_arb_fe_ack    = fe_ack_q;
   assign o_arb_fe_rdata  = fe_rdata_q;
   assign o_arb_ls_ack    = ls_ack_q;
   assign o_arb_ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_idli_sqi_arb_m.sv
// Directed bench for idli_sqi_arb_m: a transaction-level reference model plus
// literal expectations for the documented scenarios.
module tb_idli_sqi_arb_m;

   localparam int unsigned ADDR_W     = 16;
   localparam int unsigned DATA_W     = 16;
   localparam int unsigned STARVE_MAX = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              fe_req;
   logic [ADDR_W-1:0] fe_addr;
   logic              fe_ack;
   logic [DATA_W-1:0] fe_rdata;
   logic              ls_req;
   logic              ls_wr;
   logic [ADDR_W-1:0] ls_addr;
   logic [DATA_W-1:0] ls_wdata;
   logic              ls_ack;
   logic [DATA_W-1:0] ls_rdata;
   logic              sqi_req;
   logic              sqi_wr;
   logic [ADDR_W-1:0] sqi_addr;
   logic [DATA_W-1:0] sqi_wdata;
   logic              sqi_ack;
   logic [DATA_W-1:0] sqi_rdata;

   always #5 clk = ~clk;

   idli_sqi_arb_m #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
   ) dut (
      .i_arb_gck      (clk),
      .i_arb_rst_n    (rst_n),
      .i_arb_fe_req   (fe_req),
      .i_arb_fe_addr  (fe_addr),
      .o_arb_fe_ack   (fe_ack),
      .o_arb_fe_rdata (fe_rdata),
      .i_arb_ls_req   (ls_req),
      .i_arb_ls_wr    (ls_wr),
      .i_arb_ls_addr  (ls_addr),
      .i_arb_ls_wdata (ls_wdata),
      .o_arb_ls_ack   (ls_ack),
      .o_arb_ls_rdata (ls_rdata),
      .o_arb_sqi_req  (sqi_req),
      .o_arb_sqi_wr   (sqi_wr),
      .o_arb_sqi_addr (sqi_addr),
      .o_arb_sqi_wdata(sqi_wdata),
      .i_arb_sqi_ack  (sqi_ack),
      .i_arb_sqi_rdata(sqi_rdata)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: one in-flight transaction record (owner 0 = none, 1 = FE, 2 = LS).
   int              m_owner = 0;
   logic            m_wr;
   logic [15:0]     m_addr;
   logic [15:0]     m_wdata;
   logic            m_fe_ack;
   logic            m_ls_ack;
   logic [15:0]     m_fe_rdata;
   logic [15:0]     m_ls_rdata;
   int              m_cnt;
   int              spurious = 0;
   bit              mf_eff;
   bit              ml_eff;
   bit              m_pick_fe;
   int              grant_log[$];

   task automatic model_step();
      if (!rst_n) begin
         m_owner = 0; m_wr = 0; m_addr = 0; m_wdata = 0;
         m_fe_ack = 0; m_ls_ack = 0; m_fe_rdata = 0; m_ls_rdata = 0; m_cnt = 0;
      end else begin
         mf_eff   = fe_req && !m_fe_ack;
         ml_eff   = ls_req && !m_ls_ack;
         m_fe_ack = 0;
         m_ls_ack = 0;
         if (m_owner == 0) begin
            if (sqi_ack) spurious++;
`ifdef IDLI_ARB_STARVE_EN
            m_pick_fe = mf_eff && (!ml_eff || m_cnt == int'(STARVE_MAX));
`else
            m_pick_fe = mf_eff && !ml_eff;
`endif
            if (m_pick_fe) begin
               m_owner = 1; m_wr = 0; m_addr = fe_addr; m_wdata = 0; m_cnt = 0;
            end else if (ml_eff) begin
               m_owner = 2; m_wr = ls_wr; m_addr = ls_addr; m_wdata = ls_wdata;
               if (mf_eff && m_cnt < int'(STARVE_MAX)) m_cnt = m_cnt + 1;
            end
         end else if (sqi_ack) begin
            if (m_owner == 1) begin
               m_fe_ack = 1; m_fe_rdata = sqi_rdata;
            end else begin
               m_ls_ack = 1; m_ls_rdata = m_wr ? 16'h0 : sqi_rdata;
            end
            m_owner = 0;
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // Compare DUT against the model on every falling edge.
   initial forever begin
      @(negedge clk);
      chk("m_sqi_req", 32'(sqi_req), 32'(m_owner != 0));
      chk("m_fe_ack", 32'(fe_ack), 32'(m_fe_ack));
      chk("m_ls_ack", 32'(ls_ack), 32'(m_ls_ack));
      if (m_owner != 0) begin
         chk("m_sqi_wr", 32'(sqi_wr), 32'(m_wr));
         chk("m_sqi_addr", 32'(sqi_addr), 32'(m_addr));
         chk("m_sqi_wdata", 32'(sqi_wdata), 32'(m_wdata));
      end
      if (m_fe_ack) chk("m_fe_rdata", 32'(fe_rdata), 32'(m_fe_rdata));
      if (m_ls_ack) chk("m_ls_rdata", 32'(ls_rdata), 32'(m_ls_rdata));
      if (fe_ack) grant_log.push_back(1);
      if (ls_ack) grant_log.push_back(2);
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic ack_sqi(input logic [15:0] d);
      sqi_ack   = 1'b1;
      sqi_rdata = d;
      step(1);
      sqi_ack   = 1'b0;
   endtask

   int exp_order[6];
   int base;

   initial begin
`ifdef IDLI_ARB_STARVE_EN
      exp_order = '{2, 2, 2, 2, 1, 2};
`else
      exp_order = '{2, 2, 2, 2, 2, 2};
`endif
      rst_n = 0; fe_req = 0; fe_addr = 0; ls_req = 0; ls_wr = 0; ls_addr = 0;
      ls_wdata = 0; sqi_ack = 0; sqi_rdata = 0;
      step(3);
      chk("rst_sqi_req", 32'(sqi_req), 0);
      chk("rst_sqi_addr", 32'(sqi_addr), 0);
      chk("rst_fe_ack", 32'(fe_ack), 0);
      chk("rst_ls_rdata", 32'(ls_rdata), 0);
      rst_n = 1;
      step(1);

      // Single fetch: request in cycle 1, SQI ack in cycle 5.
      fe_req = 1; fe_addr = 16'h1234;
      chk("f_req_c1", 32'(sqi_req), 0);
      step(1);
      chk("f_req_c2", 32'(sqi_req), 1);
      chk("f_addr_c2", 32'(sqi_addr), 32'h1234);
      chk("f_wr_c2", 32'(sqi_wr), 0);
      step(3);
      chk("f_req_c5", 32'(sqi_req), 1);
      ack_sqi(16'hBEEF);
      chk("f_ack_c6", 32'(fe_ack), 1);
      chk("f_rdata_c6", 32'(fe_rdata), 32'hBEEF);
      chk("f_req_c6", 32'(sqi_req), 0);
      step(1);
      fe_req = 0;
      chk("f_noregrant", 32'(sqi_req), 0);
      chk("f_ack_c7", 32'(fe_ack), 0);

      // Store: write data held while busy, load data returned as 0.
      ls_req = 1; ls_wr = 1; ls_addr = 16'h0010; ls_wdata = 16'hA5A5;
      step(1);
      chk("s_wr", 32'(sqi_wr), 1);
      chk("s_addr", 32'(sqi_addr), 32'h0010);
      chk("s_wdata", 32'(sqi_wdata), 32'hA5A5);
      ls_wdata = 16'h1111; ls_addr = 16'h0777;
      step(1);
      chk("s_wdata_hold", 32'(sqi_wdata), 32'hA5A5);
      chk("s_addr_hold", 32'(sqi_addr), 32'h0010);
      ack_sqi(16'h7777);
      chk("s_ack", 32'(ls_ack), 1);
      chk("s_rdata", 32'(ls_rdata), 0);
      step(1);
      ls_req = 0; ls_wr = 0;
      chk("s_noregrant", 32'(sqi_req), 0);

      // Simultaneous requests: LS first, FE granted in the LS ack cycle.
      fe_req = 1; fe_addr = 16'h2000; ls_req = 1; ls_addr = 16'h3000;
      step(1);
      chk("b_first_addr", 32'(sqi_addr), 32'h3000);
      step(1);
      ack_sqi(16'h1111);
      chk("b_ls_ack", 32'(ls_ack), 1);
      chk("b_ls_rdata", 32'(ls_rdata), 32'h1111);
      chk("b_gap", 32'(sqi_req), 0);
      step(1);
      chk("b_fe_granted", 32'(sqi_req), 1);
      chk("b_fe_addr", 32'(sqi_addr), 32'h2000);
      ls_req = 0;
      step(1);
      ack_sqi(16'h2222);
      chk("b_fe_ack", 32'(fe_ack), 1);
      chk("b_fe_rdata", 32'(fe_rdata), 32'h2222);
      step(1);
      fe_req = 0;
      chk("b_idle", 32'(sqi_req), 0);

      // Starvation rounds: both requesters raise together from a quiet IDLE and
      // withdraw while the winner is being served, so only the counter decides.
      base = grant_log.size();
      for (int r = 0; r < 6; r++) begin
         fe_req = 1; fe_addr = 16'(16'h4000 + r);
         ls_req = 1; ls_wr = 0; ls_addr = 16'(16'h5000 + r);
         step(1);
         chk("st_req", 32'(sqi_req), 1);
         chk("st_addr", 32'(sqi_addr), (exp_order[r] == 1) ? 32'(16'h4000 + r) : 32'(16'h5000 + r));
         fe_req = 0; ls_req = 0;
         step(1);
         ack_sqi(16'(16'h6000 + r));
         step(1);
      end
      chk("st_log_len", 32'(grant_log.size() - base), 6);
      for (int r = 0; r < 6; r++) begin
         if (base + r < grant_log.size()) chk("st_order", 32'(grant_log[base + r]), 32'(exp_order[r]));
      end

      // Reset while in BUSY_LS, then a late SQI ack after release.
      ls_req = 1; ls_wr = 0; ls_addr = 16'h0ABC;
      step(1);
      chk("r_busy", 32'(sqi_req), 1);
      step(1);
      rst_n = 0; ls_req = 0;
      step(2);
      rst_n = 1;
      step(1);
      ack_sqi(16'hDEAD);
      chk("r_sqi_req", 32'(sqi_req), 0);
      chk("r_sqi_wr", 32'(sqi_wr), 0);
      chk("r_sqi_addr", 32'(sqi_addr), 0);
      chk("r_sqi_wdata", 32'(sqi_wdata), 0);
      chk("r_ls_ack", 32'(ls_ack), 0);
      chk("r_fe_ack", 32'(fe_ack), 0);
      chk("r_ls_rdata", 32'(ls_rdata), 0);
      step(1);
      chk("r_ls_ack_late", 32'(ls_ack), 0);

      // Spurious SQI ack in IDLE, then a normal fetch still works.
      ack_sqi(16'h5555);
      chk("sp_req", 32'(sqi_req), 0);
      chk("sp_fe_ack", 32'(fe_ack), 0);
      chk("sp_ls_ack", 32'(ls_ack), 0);
      step(1);
      fe_req = 1; fe_addr = 16'h0042;
      step(2);
      ack_sqi(16'h0042);
      chk("sp_fe_ack_ok", 32'(fe_ack), 1);
      chk("sp_fe_rdata", 32'(fe_rdata), 32'h0042);
      step(1);
      fe_req = 0;
      step(2);

      // Exactly the two deliberately injected IDLE acks are protocol violations.
      chk("spurious_cnt", 32'(spurious), 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Hard bound in case the stimulus ever stalls.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
